// File: rtl/half_adder.sv
// Bit-parallel half adder: each lane produces sum = a ^ b and carry = a & b.
// PIPE=0 is a purely combinational cell, and the handshake passes straight through.
// PIPE=1 adds one output register stage with a valid/ready handshake.
// The stage can accept a new pair on the same cycle that it drains its current result.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int PIPE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready
);

    if (PIPE == 0) begin : g_comb
        // clk and rst only matter in the registered build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        // Zero-latency lane arithmetic and handshake pass-through.
        always_comb begin
            sum       = a ^ b;
            carry     = a & b;
            out_valid = in_valid;
            in_ready  = out_ready;
        end
    end else begin : g_pipe
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] carry_q;
        logic             valid_q;
        logic             accept;

        // The stage takes a new pair when it is empty or is being drained this cycle.
        always_comb begin
            in_ready  = !valid_q || out_ready;
            accept    = in_valid && in_ready;
            sum       = sum_q;
            carry     = carry_q;
            out_valid = valid_q;
        end

        // Output stage: reset clears it, accept loads it, drain empties it, otherwise hold.
        // Data is left untouched on drain, so an empty stage shows the last result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= '0;
                valid_q <= 1'b0;
            end else if (accept) begin
                sum_q   <= a ^ b;
                carry_q <= a & b;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: combinational cells, a full adder built from two cells, and a
// WIDTH=8 registered stage checked against a queue-based model.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Registered 8-lane DUT
    logic [7:0] a, b, carry, sum;
    logic       in_valid, in_ready, out_valid, out_ready;

    half_adder #(.WIDTH(8), .PIPE(1)) dut (
        .clk(clk), .rst(rst), .carry(carry), .sum(sum), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Single combinational cell
    logic ca, cb, cc, cs, c_iv, c_ir, c_ov, c_or;

    half_adder #(.WIDTH(1), .PIPE(0)) u_comb (
        .clk(clk), .rst(rst), .carry(cc), .sum(cs), .a(ca), .b(cb),
        .in_valid(c_iv), .in_ready(c_ir), .out_valid(c_ov), .out_ready(c_or)
    );

    // Full adder assembled from two combinational cells and an OR
    logic fa_a, fa_b, fa_cin, c1, s1, c2, s2, fa_cout;
    logic fa_unused_ir1, fa_unused_ov1, fa_unused_ir2, fa_unused_ov2;

    half_adder #(.WIDTH(1), .PIPE(0)) u_fa_h1 (
        .clk(clk), .rst(rst), .carry(c1), .sum(s1), .a(fa_a), .b(fa_b),
        .in_valid(1'b0), .in_ready(fa_unused_ir1), .out_valid(fa_unused_ov1), .out_ready(1'b0)
    );
    half_adder #(.WIDTH(1), .PIPE(0)) u_fa_h2 (
        .clk(clk), .rst(rst), .carry(c2), .sum(s2), .a(s1), .b(fa_cin),
        .in_valid(1'b0), .in_ready(fa_unused_ir2), .out_valid(fa_unused_ov2), .out_ready(1'b0)
    );
    assign fa_cout = c1 | c2;

    // Model of the registered stage: a queue holding at most one {carry,sum} result
    logic [15:0] mq[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: each lane's 2-bit arithmetic sum split into carry and sum
    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] c, s;
        logic [1:0] t;
        for (int i = 0; i < 8; i++) begin
            t    = 2'(x[i]) + 2'(y[i]);
            c[i] = t[1];
            s[i] = t[0];
        end
        return {c, s};
    endfunction

    // One clock of the registered DUT. Inputs are set at posedge+1. Ready is checked
    // at posedge+2, and the outputs are checked at posedge+1 of the next edge.
    task automatic step();
        logic acc, drn;
        #1;
        acc = in_valid && ((mq.size() == 0) || out_ready);
        drn = (mq.size() > 0) && out_ready;
        check("in_ready", 16'(in_ready), 16'((mq.size() == 0) || out_ready));
        @(posedge clk);
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(ref8(a, b));
        #1;
        check("out_valid", 16'(out_valid), 16'(mq.size() > 0));
        if (mq.size() > 0) check("data", {carry, sum}, mq[0]);
    endtask

    initial begin
        logic [15:0] frozen;
        int k;
        a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        ca = 0; cb = 0; c_iv = 0; c_or = 0;
        fa_a = 0; fa_b = 0; fa_cin = 0;

        // Values seen while reset is held
        #2;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_data", {carry, sum}, 16'h0000);
        check("rst_in_ready", 16'(in_ready), 16'd1);

        // Test 1: combinational truth table and handshake pass-through
        for (int i = 0; i < 4; i++) begin
            ca = i[1]; cb = i[0]; c_iv = i[0]; c_or = i[1];
            #1;
            check("comb_cs", {14'd0, cc, cs}, 16'(2'(ca) + 2'(cb)));
            check("comb_ov", 16'(c_ov), 16'(c_iv));
            check("comb_ir", 16'(c_ir), 16'(c_or));
        end

        // Test 2: full adder, listed vectors first and then all eight
        for (int i = 0; i < 12; i++) begin
            k = (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 0 : (i == 3) ? 7 : i - 4;
            fa_a = k[2]; fa_b = k[1]; fa_cin = k[0];
            #1;
            check("full_adder", {14'd0, fa_cout, s2}, 16'(2'(fa_a) + 2'(fa_b) + 2'(fa_cin)));
        end

        // Leave reset away from the clock edge
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 3: a single transaction with a 1-cycle latency
        a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("t3_sum", 16'(sum), 16'h00CC);
        check("t3_carry", 16'(carry), 16'h0030);
        check("t3_valid", 16'(out_valid), 16'd1);

        // Test 4: backpressure freezes the outputs and refuses new operands
        out_ready = 1'b0; a = 8'hAA; b = 8'hFF;
        step();
        frozen = {carry, sum};
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            step();
            check("t4_frozen", {carry, sum}, frozen);
            check("t4_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1; a = 8'h5A; b = 8'h0F;
        step();
        check("t4_accept", {carry, sum}, 16'h0A55);

        // Test 5: asynchronous reset while a result is held
        in_valid = 1'b1; out_ready = 1'b0; a = 8'hFF; b = 8'hFF;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("t5_out_valid", 16'(out_valid), 16'd0);
        check("t5_data", {carry, sum}, 16'h0000);
        check("t5_in_ready", 16'(in_ready), 16'd1);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Test 6: 100 random pairs streamed with out_ready held high
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            step();
            check("t6_no_gap", 16'(out_valid), 16'd1);
        end

        // Random valid and ready traffic
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
